// File: rtl/mem_port_master.sv
// mem_port_master: request/response front end driving a single-port
// synchronous memory. Single-word writes are acknowledged with one beat.
// Burst reads of 1..16 beats are streamed out with a two-cycle
// issue-to-beat latency.
// Optional feature macro: MEM_RANGE_CHECK_EN. When defined, requests outside
// mem_depth are rejected with a single error beat.

`ifndef DATA_WORD_SIZE
`define DATA_WORD_SIZE 8
`endif
`ifndef DATA_ADDR_SIZE
`define DATA_ADDR_SIZE 8
`endif

module mem_port_master #(
    parameter int word_size = `DATA_WORD_SIZE,
    parameter int addr_size = `DATA_ADDR_SIZE,
    parameter int mem_depth = 2**addr_size
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [addr_size-1:0] req_addr,
    input  logic [word_size-1:0] req_data,
    input  logic [3:0]           req_len,
    output logic                 rsp_valid,
    output logic [word_size-1:0] rsp_data,
    output logic                 rsp_last,
    output logic                 rsp_err,
    output logic                 mem_w_en,
    output logic [addr_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_d_in,
    input  logic [word_size-1:0] mem_d_out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_WRITE,
        ST_ACK
    } state_t;

    state_t               state_reg;
    logic [3:0]           count_reg;       // read issues still to go after the current one
    logic                 pipe_valid_reg;  // a read address was issued last cycle
    logic                 pipe_last_reg;   // ... and it was the final one of the burst
    logic                 rsp_valid_reg;
    logic                 rsp_last_reg;
    logic [word_size-1:0] rsp_data_reg;
    logic                 mem_w_en_reg;
    logic [addr_size-1:0] mem_addr_reg;
    logic [word_size-1:0] mem_d_in_reg;
    logic                 range_fault;

`ifdef MEM_RANGE_CHECK_EN
    localparam logic [addr_size:0] depth_lim = (addr_size+1)'(mem_depth);

    logic                 rsp_err_reg;
    logic [addr_size:0]   start_ext;
    logic [addr_size:0]   end_ext;

    // Range test is done one bit wider than the address so the burst end never wraps
    always_comb begin
        start_ext   = {1'b0, req_addr};
        end_ext     = start_ext + (addr_size+1)'(req_len);
        range_fault = (start_ext >= depth_lim) || (!req_we && (end_ext >= depth_lim));
    end

    assign rsp_err = rsp_err_reg;
`else
    localparam int unused_mem_depth = mem_depth;

    assign range_fault = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // Control FSM with the read-return pipeline and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            count_reg      <= '0;
            pipe_valid_reg <= 1'b0;
            pipe_last_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_last_reg   <= 1'b0;
            rsp_data_reg   <= '0;
            mem_w_en_reg   <= 1'b0;
            mem_addr_reg   <= '0;
            mem_d_in_reg   <= '0;
`ifdef MEM_RANGE_CHECK_EN
            rsp_err_reg    <= 1'b0;
`endif
        end else begin
            // Read data returned by the memory one cycle after issue is
            // registered straight into the response stage.
            pipe_valid_reg <= 1'b0;
            pipe_last_reg  <= 1'b0;
            rsp_valid_reg  <= pipe_valid_reg;
            rsp_last_reg   <= pipe_last_reg;
            rsp_data_reg   <= pipe_valid_reg ? mem_d_out : '0;
            mem_w_en_reg   <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            rsp_err_reg    <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (range_fault) begin
                            // Rejected: error beat next cycle, no memory access
                            state_reg     <= ST_ACK;
                            rsp_valid_reg <= 1'b1;
                            rsp_last_reg  <= 1'b1;
`ifdef MEM_RANGE_CHECK_EN
                            rsp_err_reg   <= 1'b1;
`endif
                        end else if (req_we) begin
                            state_reg    <= ST_WRITE;
                            mem_w_en_reg <= 1'b1;
                            mem_addr_reg <= req_addr;
                            mem_d_in_reg <= req_data;
                        end else begin
                            state_reg    <= ST_READ;
                            mem_addr_reg <= req_addr;
                            count_reg    <= req_len;
                        end
                    end
                end
                ST_READ: begin
                    pipe_valid_reg <= 1'b1;
                    pipe_last_reg  <= (count_reg == 4'd0);
                    if (count_reg == 4'd0) begin
                        state_reg <= ST_DRAIN;
                    end else begin
                        mem_addr_reg <= mem_addr_reg + 1'b1;
                        count_reg    <= count_reg - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Leave once the final beat is on the outputs
                    if (rsp_last_reg) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state_reg     <= ST_ACK;
                    rsp_valid_reg <= 1'b1;
                    rsp_last_reg  <= 1'b1;
                    rsp_data_reg  <= '0;
                end
                ST_ACK: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_last  = rsp_last_reg;
    assign rsp_data  = rsp_data_reg;
    assign mem_w_en  = mem_w_en_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_d_in  = mem_d_in_reg;

endmodule

// File: doc/mem_port_master.md
MEM_PORT_MASTER -- requirements
Module: mem_port_master

Interface
REQ-001 Parameter word_size, default `DATA_WORD_SIZE, sets the data word width.
REQ-002 Parameter addr_size, default `DATA_ADDR_SIZE, sets the memory address width.
REQ-003 Parameter mem_depth, default 2**addr_size, sets the number of valid memory words; used only under MEM_RANGE_CHECK_EN.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  master accepts a request this cycle.
REQ-008 req_we  input  1  1 = single-word write, 0 = burst read.
REQ-009 req_addr  input  addr_size  start address.
REQ-010 req_data  input  word_size  write data.
REQ-011 req_len  input  4  read beats minus one (1..16 beats); ignored for writes.
REQ-012 rsp_valid  output  1  response beat valid.
REQ-013 rsp_data  output  word_size  read data; 0 on write ack and on error.
REQ-014 rsp_last  output  1  final beat of the response.
REQ-015 rsp_err  output  1  request rejected (range fault).
REQ-016 mem_w_en  output  1  memory write enable.
REQ-017 mem_addr  output  addr_size  memory address.
REQ-018 mem_d_in  output  word_size  memory write data.
REQ-019 mem_d_out  input  word_size  memory read data, registered by the memory one cycle after the address is presented with mem_w_en=0.

Function
REQ-020 States IDLE, READ, DRAIN, WRITE, ACK; req_ready SHALL be 1 only in IDLE.
REQ-021 Acceptance = req_valid && req_ready at edge T; req_* sampled only then.
REQ-022 Write: IDLE->WRITE; in cycle T+1 mem_w_en=1, mem_addr=req_addr, mem_d_in=req_data; WRITE->ACK; in T+2 rsp_valid=1, rsp_last=1, rsp_data=0; ACK->IDLE.
REQ-023 Read: IDLE->READ; READ lasts req_len+1 cycles, mem_addr = start, start+1, ... one per cycle, mem_w_en=0.
REQ-024 Address increment SHALL wrap modulo 2**addr_size (e.g. 0xFF+1 -> 0x00 for addr_size=8).
REQ-025 Each issued read SHALL produce exactly one rsp beat, rsp_data registered from mem_d_out: beat for address issued in cycle C has rsp_valid=1 in cycle C+2, in issue order, back-to-back.
REQ-026 rsp_last SHALL be 1 only on the beat of the final issued address.
REQ-027 READ->DRAIN after final issue; DRAIN holds until the last beat is output, then ->IDLE; req_ready SHALL rise the cycle after rsp_last.
REQ-028 No backpressure: the consumer SHALL always sample rsp_* when rsp_valid=1.
REQ-029 mem_w_en SHALL be 0 in every state except WRITE; mem_addr/mem_d_in hold last value when idle.
REQ-030 req_valid while req_ready=0 SHALL be ignored with no side effect.

Reset
REQ-031 On rst=1 at an edge: state=IDLE, mem_w_en=0, mem_addr=0, mem_d_in=0, rsp_valid=0, rsp_last=0, rsp_err=0, rsp_data=0, in-flight read beats discarded.
REQ-032 Reset mid-burst or mid-write SHALL produce no further rsp beats; req_ready=1 the first cycle after rst deasserts.

Configuration
REQ-033 Macro MEM_RANGE_CHECK_EN defined: request with req_addr>=mem_depth, or read with req_addr+req_len>=mem_depth (no wrap), SHALL cause no memory access and one beat at T+1 with rsp_valid=1, rsp_err=1, rsp_last=1, rsp_data=0, then IDLE.
REQ-034 Macro undefined: no range check, rsp_err tied 0, addresses wrap per REQ-024.

Verification
REQ-035 Write 0xA5 to addr 3 accepted at T -> T+1 mem_w_en=1, mem_addr=3, mem_d_in=0xA5; T+2 rsp_valid=1, rsp_last=1.
REQ-036 Read addr 4, req_len=3, memory holds 10,11,12,13 -> mem_addr 4..7 in T+1..T+4; beats 10,11,12,13 in T+3..T+6; rsp_last only at T+6; req_ready=1 at T+7.
REQ-037 Read addr 0xFE, req_len=2, addr_size=8, macro undefined -> mem_addr 0xFE,0xFF,0x00; three beats, rsp_err=0.
REQ-038 Same as REQ-037 with MEM_RANGE_CHECK_EN, mem_depth=256 -> no mem access, single beat rsp_err=1, rsp_last=1 at T+1.
REQ-039 rst asserted at T+2 of a 16-beat read -> from T+3 rsp_valid=0, mem_w_en=0, req_ready=1 once rst drops.
REQ-040 Write then read of same address issued back-to-back -> read returns written value; req_valid held during ACK is not accepted until IDLE.
